// File: rtl/jtframe_rom_loader.sv
// ROM download stage: ioctl byte stream to SDRAM programming writes.
// Strips the file header, splits banks, diverts PROM bytes, 4-deep FIFO.
module jtframe_rom_loader #(
    parameter logic [24:0] HEADER     = 25'd0,
    parameter logic [24:0] BA1_START  = 25'h100000,
    parameter logic [24:0] BA2_START  = 25'h200000,
    parameter logic [24:0] BA3_START  = 25'h300000,
    parameter logic [24:0] PROM_START = 25'h1F00000,
    parameter logic        SWAB       = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        downloading,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    output logic [21:0] prog_addr,
    output logic [7:0]  prog_data,
    output logic [1:0]  prog_mask,
    output logic [1:0]  prog_bank,
    output logic        prog_we,
    input  logic        prog_rdy,
    output logic        prom_we,
    output logic        dwnld_busy,
    output logic        overflow
);

    typedef struct packed {
        logic [21:0] addr;
        logic [7:0]  data;
        logic [1:0]  mask;
        logic [1:0]  bank;
    } entry_t;

    entry_t      mem [4];
    entry_t      head;
    entry_t      entry;
    logic [1:0]  rd_ptr;
    logic [1:0]  wr_ptr;
    logic [2:0]  count;
    logic [21:0] prom_addr;
    logic [7:0]  prom_data;
    logic        dl_q;

    logic [24:0] off;
    logic [24:0] rel;
    logic [1:0]  bank;
    logic        is_prom;
    logic        accept;
    logic        push;
    logic        prom_hit;
    logic        pop;
    logic        full;
    logic        drop;
    logic        wr_en;
    logic        unused;

    // Highest threshold wins, so PROM_START >= BA3_START keeps regions disjoint
    always_comb begin
        off     = ioctl_addr - HEADER;
        rel     = off;
        bank    = 2'd0;
        is_prom = 1'b0;
        if (off >= PROM_START) begin
            is_prom = 1'b1;
            rel     = off - PROM_START;
        end else if (off >= BA3_START) begin
            bank = 2'd3;
            rel  = off - BA3_START;
        end else if (off >= BA2_START) begin
            bank = 2'd2;
            rel  = off - BA2_START;
        end else if (off >= BA1_START) begin
            bank = 2'd1;
            rel  = off - BA1_START;
        end
    end

    assign unused = ^rel[24:23];

    always_comb begin
        entry.addr = rel[22:1];
        entry.data = ioctl_data;
        entry.mask = (rel[0] ^ SWAB) ? 2'b01 : 2'b10;
        entry.bank = bank;
    end

    assign accept   = ioctl_wr && downloading && (ioctl_addr >= HEADER);
    assign push     = accept && !is_prom;
    assign prom_hit = accept && is_prom;
    assign full     = (count == 3'd4);
    assign pop      = prog_rdy && prog_we;
    // A full FIFO still takes a byte when the head leaves in the same cycle
    assign drop     = push && full && !pop;
    assign wr_en    = push && !drop;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= 2'd0;
            wr_ptr    <= 2'd0;
            count     <= 3'd0;
            prom_we   <= 1'b0;
            prom_addr <= 22'd0;
            prom_data <= 8'd0;
            dl_q      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 2'd1;
            if (pop)   rd_ptr <= rd_ptr + 2'd1;
            unique case ({wr_en, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            prom_we <= prom_hit;
            if (prom_hit) begin
                prom_addr <= rel[21:0];
                prom_data <= ioctl_data;
            end
            dl_q     <= downloading;
            overflow <= (overflow && !(downloading && !dl_q)) || drop;
        end
    end

    assign head = mem[rd_ptr];

    // The PROM strobe borrows addr/data for one cycle; the head stays queued
    always_comb begin
        prog_we   = (count != 3'd0) && !prom_we;
        prog_addr = 22'd0;
        prog_data = 8'd0;
        prog_mask = 2'b11;
        prog_bank = 2'd0;
        if (count != 3'd0) begin
            prog_addr = head.addr;
            prog_data = head.data;
            prog_mask = head.mask;
            prog_bank = head.bank;
        end
        if (prom_we) begin
            prog_addr = prom_addr;
            prog_data = prom_data;
        end
    end

    assign dwnld_busy = downloading | (count != 3'd0) | prom_we;

endmodule

// File: tb/tb_jtframe_rom_loader.sv
// Directed bench for jtframe_rom_loader: header, banks, FIFO, PROM, reset.
// Instance a uses HEADER=16; instance b uses HEADER=0 with SWAB=1.
module tb_jtframe_rom_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        downloading;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;
    logic        prog_rdy;

    logic [21:0] a_addr, b_addr;
    logic [7:0]  a_data, b_data;
    logic [1:0]  a_mask, b_mask;
    logic [1:0]  a_bank, b_bank;
    logic        a_we, b_we;
    logic        a_prom, b_prom;
    logic        a_busy, b_busy;
    logic        a_ovf, b_ovf;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    jtframe_rom_loader #(.HEADER(25'd16)) u_a (
        .clk(clk), .rst(rst), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
        .ioctl_wr(ioctl_wr),
        .prog_addr(a_addr), .prog_data(a_data), .prog_mask(a_mask),
        .prog_bank(a_bank), .prog_we(a_we), .prog_rdy(prog_rdy),
        .prom_we(a_prom), .dwnld_busy(a_busy), .overflow(a_ovf)
    );

    jtframe_rom_loader #(.HEADER(25'd0), .SWAB(1'b1)) u_b (
        .clk(clk), .rst(rst), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
        .ioctl_wr(ioctl_wr),
        .prog_addr(b_addr), .prog_data(b_data), .prog_mask(b_mask),
        .prog_bank(b_bank), .prog_we(b_we), .prog_rdy(prog_rdy),
        .prom_we(b_prom), .dwnld_busy(b_busy), .overflow(b_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [24:0] addr, input logic [7:0] data);
        ioctl_addr = addr;
        ioctl_data = data;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic rdy();
        prog_rdy = 1'b1;
        tick();
        prog_rdy = 1'b0;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        downloading = 1'b0;
        ioctl_wr    = 1'b0;
        prog_rdy    = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [39:0] got, exp;
        ioctl_addr = '0;
        ioctl_data = '0;
        do_reset();
        got = {a_addr, a_data, a_mask, a_bank, a_we, a_prom, a_busy, a_ovf};
        exp = {22'd0, 8'd0, 2'b11, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL reset_values got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_header();
        logic [34:0] got, exp;
        do_reset();
        downloading = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr(25'(i), 8'(i + 8'h80));
            checks++;
            if (a_we !== 1'b0) begin
                failures++;
                $display("FAIL header_skip addr=%0d prog_we=%b exp=0", i, a_we);
            end
        end
        wr(25'd16, 8'hA5);
        got = {a_we, a_addr, a_mask, a_bank, a_data};
        exp = {1'b1, 22'd0, 2'b10, 2'd0, 8'hA5};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL header_first got=%h exp=%h", got, exp);
        end
        rdy();
        checks++;
        if (a_we !== 1'b0) begin
            failures++;
            $display("FAIL header_pop prog_we=%b exp=0", a_we);
        end
    endtask

    task automatic test_bank_split();
        logic [34:0] got, exp;
        do_reset();
        downloading = 1'b1;
        wr(25'h100003 + 25'd16, 8'h11);
        got = {a_we, a_addr, a_mask, a_bank, a_data};
        exp = {1'b1, 22'd1, 2'b01, 2'd1, 8'h11};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL bank1_odd got=%h exp=%h", got, exp);
        end
        rdy();
        wr(25'h300000 + 25'd16, 8'h22);
        got = {a_we, a_addr, a_mask, a_bank, a_data};
        exp = {1'b1, 22'd0, 2'b10, 2'd3, 8'h22};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL bank3_even got=%h exp=%h", got, exp);
        end
        rdy();
    endtask

    task automatic test_swab();
        logic [34:0] got, exp;
        do_reset();
        downloading = 1'b1;
        wr(25'h100003, 8'h33);
        got = {b_we, b_addr, b_mask, b_bank, b_data};
        exp = {1'b1, 22'd1, 2'b10, 2'd1, 8'h33};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL swab_bank1 got=%h exp=%h", got, exp);
        end
        rdy();
        wr(25'h300000, 8'h44);
        got = {b_we, b_addr, b_mask, b_bank, b_data};
        exp = {1'b1, 22'd0, 2'b01, 2'd3, 8'h44};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL swab_bank3 got=%h exp=%h", got, exp);
        end
        rdy();
    endtask

    task automatic test_overflow();
        do_reset();
        downloading = 1'b1;
        for (int i = 0; i < 4; i++) wr(25'(16 + i), 8'(i + 1));
        checks++;
        if (a_ovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_at_four got=%b exp=0", a_ovf);
        end
        wr(25'd20, 8'd5);
        checks++;
        if (a_ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set got=%b exp=1", a_ovf);
        end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (a_we !== 1'b1 || a_data !== 8'(i)) begin
                failures++;
                $display("FAIL ovf_order%0d we=%b data=%h exp=1/%h",
                         i, a_we, a_data, 8'(i));
            end
            rdy();
        end
        checks++;
        if (a_we !== 1'b0 || a_ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_drain we=%b ovf=%b exp=0/1", a_we, a_ovf);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        downloading = 1'b1;
        for (int i = 0; i < 4; i++) wr(25'(16 + i), 8'(8'h10 + i));
        ioctl_addr = 25'd20;
        ioctl_data = 8'h14;
        ioctl_wr   = 1'b1;
        prog_rdy   = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        prog_rdy = 1'b0;
        checks++;
        if (a_ovf !== 1'b0) begin
            failures++;
            $display("FAIL full_pp_ovf got=%b exp=0", a_ovf);
        end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (a_we !== 1'b1 || a_data !== 8'(8'h10 + i)) begin
                failures++;
                $display("FAIL full_pp_order%0d we=%b data=%h exp=1/%h",
                         i, a_we, a_data, 8'(8'h10 + i));
            end
            rdy();
        end
        checks++;
        if (a_we !== 1'b0) begin
            failures++;
            $display("FAIL full_pp_empty we=%b exp=0", a_we);
        end
    endtask

    task automatic test_prom();
        logic [34:0] got, exp;
        do_reset();
        downloading = 1'b1;
        wr(25'd18, 8'h77);
        wr(25'h1F00005 + 25'd16, 8'h3C);
        got = {a_prom, a_we, a_addr, a_data, 3'b000};
        exp = {1'b1, 1'b0, 22'd5, 8'h3C, 3'b000};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL prom_strobe got=%h exp=%h", got, exp);
        end
        tick();
        got = {a_prom, a_we, a_addr, a_data, a_mask, a_bank[0]};
        exp = {1'b0, 1'b1, 22'd1, 8'h77, 2'b10, 1'b0};
        checks++;
        if (got !== exp || a_bank !== 2'd0) begin
            failures++;
            $display("FAIL prom_head got=%h exp=%h", got, exp);
        end
        rdy();
        checks++;
        if (a_we !== 1'b0 || a_prom !== 1'b0) begin
            failures++;
            $display("FAIL prom_drain we=%b prom=%b exp=0/0", a_we, a_prom);
        end
    endtask

    task automatic test_end_of_download();
        do_reset();
        downloading = 1'b1;
        wr(25'd16, 8'hA1);
        wr(25'd17, 8'hA2);
        downloading = 1'b0;
        wr(25'd24, 8'h99);
        checks++;
        if (a_busy !== 1'b1 || a_data !== 8'hA1) begin
            failures++;
            $display("FAIL end_busy0 busy=%b data=%h exp=1/a1", a_busy, a_data);
        end
        rdy();
        checks++;
        if (a_busy !== 1'b1 || a_data !== 8'hA2) begin
            failures++;
            $display("FAIL end_busy1 busy=%b data=%h exp=1/a2", a_busy, a_data);
        end
        rdy();
        checks++;
        if (a_busy !== 1'b0 || a_we !== 1'b0) begin
            failures++;
            $display("FAIL end_idle busy=%b we=%b exp=0/0", a_busy, a_we);
        end
    endtask

    task automatic test_reset_mid();
        logic [39:0] got, exp;
        do_reset();
        downloading = 1'b1;
        for (int i = 0; i < 3; i++) wr(25'(16 + i), 8'(8'hC0 + i));
        rst         = 1'b1;
        downloading = 1'b0;
        tick();
        rst = 1'b0;
        got = {a_addr, a_data, a_mask, a_bank, a_we, a_prom, a_busy, a_ovf};
        exp = {22'd0, 8'd0, 2'b11, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL reset_mid got=%h exp=%h", got, exp);
        end
        tick();
        checks++;
        if (a_we !== 1'b0 || a_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_count we=%b busy=%b exp=0/0", a_we, a_busy);
        end
    endtask

    initial begin
        rst         = 1'b1;
        downloading = 1'b0;
        ioctl_addr  = '0;
        ioctl_data  = '0;
        ioctl_wr    = 1'b0;
        prog_rdy    = 1'b0;
        test_reset();
        test_header();
        test_bank_split();
        test_swab();
        test_overflow();
        test_full_push_pop();
        test_prom();
        test_end_of_download();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
